toggle_debouncer: RTL and testbench

Upstream conditioning stage for the T flip-flop: it takes a raw, asynchronous, bouncing toggle request such as a push-button or an external strobe. It synchronises the request into the `clk` domain and debounces it over a programmable number of stable cycles. On each confirmed press it emits exactly one single-cycle `t` pulse, which drives the `t` input of the downstream T flip-flop directly. Releases are also debounced but produce no pulse.

---
 rtl/toggle_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/toggle_debouncer.sv | 120 ++++++++++++
 tb/tb_toggle_debouncer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// toggle_pkg: shared definitions for toggle-driven blocks.
//   tgl_state_e             - debouncer FSM state encoding (2 bits).
//   TOGGLE_DEBOUNCE_DEFAULT - default number of stable cycles to confirm an edge.
//   tgl_cnt_w()             - stability counter width for a given debounce length.
package toggle_pkg;

  localparam int unsigned TOGGLE_DEBOUNCE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } tgl_state_e;

  // One extra bit over $clog2 so DEBOUNCE_CYCLES-1 always fits with margin.
  function automatic int unsigned tgl_cnt_w(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser into the clk domain.
//   clk   - destination clock, rising edge
//   rst   - asynchronous active-low reset, clears both stages
//   d     - asynchronous input
//   q     - synchronised output (two-cycle latency)
//   q1    - first-stage output, exposed for observability only
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q1,
  output logic q
);

  logic s1_q;
  logic s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      s1_q <= d;
      s_q  <= s1_q;
    end
  end

  assign q1 = s1_q;
  assign q  = s_q;

endmodule

// File: rtl/toggle_debouncer.sv
// toggle_debouncer: synchronises and debounces a raw toggle request and emits
// one single-cycle t pulse per confirmed press (releases produce no pulse).
//   clk    - system clock, rising edge
//   rst    - asynchronous active-low reset
//   btn_in - raw asynchronous request, may bounce
//   t      - one-cycle pulse per confirmed press (drives a T flip-flop)
//   level  - debounced, synchronised level of btn_in
//   busy   - high while a press or release is being confirmed
module toggle_debouncer
  import toggle_pkg::*;
#(
  parameter  int unsigned DEBOUNCE_CYCLES = TOGGLE_DEBOUNCE_DEFAULT,
  localparam int unsigned CNT_W           = tgl_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic t,
  output logic level,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic       s1;
  logic       s;

  tgl_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             t_q,     t_d;
  logic             busy_q,  busy_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q1  (s1),
    .q   (s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      t_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
    end
  end

  // cnt holds the number of consecutive samples already seen at the new
  // level, so entering a confirm state loads 1 and the edge that sees the
  // DEBOUNCE_CYCLES-th sample (cnt == CNT_MAX) commits the change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    t_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = CONFIRM_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!s) begin
          state_d = IDLE;          // bounce: abort, no pulse
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          level_d = 1'b1;
          t_d     = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      CONFIRM_RELEASE: begin
        if (s) begin
          state_d = PRESSED;       // bounce: level stays 1, no pulse
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Registered from the next state so busy lines up with state_q.
    busy_d = (state_d == CONFIRM_PRESS) || (state_d == CONFIRM_RELEASE);
  end

  assign t     = t_q;
  assign level = level_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_toggle_debouncer.sv
module tb_toggle_debouncer;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic t, level, busy;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;
  int t_pulses = 0;

  toggle_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .t      (t),
    .level  (level),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: the synchronised value seen at an edge is the btn_in
  // sampled two edges earlier. The debounced level flips once D consecutive
  // samples disagree with it; any agreeing sample clears the run.
  bit m_hist[2];
  int m_run;
  bit m_level, m_t, m_busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hist[0] = 1'b0; m_hist[1] = 1'b0;
      m_run = 0; m_level = 1'b0; m_t = 1'b0; m_busy = 1'b0;
    end else begin
      bit sv;
      sv  = m_hist[1];
      m_t = 1'b0;
      if (sv != m_level) begin
        m_run = m_run + 1;
        if (m_run == D) begin
          m_level = sv;
          m_t     = sv;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run != 0);
      m_hist[1] = m_hist[0];
      m_hist[0] = btn_in;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("model_t", t, m_t);
      chk("model_level", level, m_level);
      chk("model_busy", busy, m_busy);
      if (t === 1'b1) t_pulses++;
    end
  end

  task automatic edge_wait();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) edge_wait();
  endtask

  initial begin
    int p0;
    bit lvl_dropped, busy_seen;

    // Asynchronous reset with btn_in high, before any clock edge.
    btn_in = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("reset_t", t, 1'b0);
    chk("reset_level", level, 1'b0);
    chk("reset_busy", busy, 1'b0);
    armed = 1'b1;
    btn_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycles(3);

    // Clean press: btn_in rises before edge 0.
    p0 = t_pulses;
    btn_in = 1'b1;
    for (int e = 0; e < 8; e++) begin
      edge_wait();
      chk($sformatf("press_busy_e%0d", e), busy, (e >= 2 && e < 5));
      chk($sformatf("press_t_e%0d", e), t, (e == 5));
      chk($sformatf("press_level_e%0d", e), level, (e >= 5));
    end
    // Hold for 40 cycles, then release before edge 0.
    cycles(32);
    btn_in = 1'b0;
    for (int e = 0; e < 7; e++) begin
      edge_wait();
      chk($sformatf("rel_level_e%0d", e), level, (e < 5));
      chk($sformatf("rel_busy_e%0d", e), busy, (e >= 2 && e < 5));
      chk($sformatf("rel_t_e%0d", e), t, 1'b0);
    end
    chk_int("hold_release_pulses", t_pulses - p0, 1);
    cycles(3);

    // Bounce on press: high 2, low 1, then high steadily -> t at edge 8.
    p0 = t_pulses;
    btn_in = 1'b1;
    for (int e = 0; e < 12; e++) begin
      if (e == 2) btn_in = 1'b0;
      if (e == 3) btn_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bounce_t_e%0d", e), t, (e == 8));
    end
    chk_int("bounce_pulses", t_pulses - p0, 1);
    chk("bounce_level", level, 1'b1);

    // Release bounce while PRESSED: drop for 2 cycles then restore.
    p0 = t_pulses;
    lvl_dropped = 1'b0;
    busy_seen = 1'b0;
    btn_in = 1'b0;
    for (int e = 0; e < 10; e++) begin
      if (e == 2) btn_in = 1'b1;
      edge_wait();
      if (level !== 1'b1) lvl_dropped = 1'b1;
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    chk("relbounce_level_held", lvl_dropped, 1'b0);
    chk("relbounce_busy_seen", busy_seen, 1'b1);
    chk("relbounce_busy_low", busy, 1'b0);
    chk_int("relbounce_pulses", t_pulses - p0, 0);
    btn_in = 1'b0;
    cycles(8);
    chk("idle_level", level, 1'b0);

    // Reset mid-confirm (cnt=2 after edge 3), released with btn_in still high.
    p0 = t_pulses;
    btn_in = 1'b1;
    cycles(4);
    chk("midconf_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("midconf_rst_t", t, 1'b0);
    chk("midconf_rst_level", level, 1'b0);
    chk("midconf_rst_busy", busy, 1'b0);
    cycles(3);
    chk_int("midconf_no_pulse", t_pulses - p0, 0);
    rst = 1'b1;
    for (int e = 0; e < 8; e++) begin
      edge_wait();
      chk($sformatf("after_rst_t_e%0d", e), t, (e == 5));
      chk($sformatf("after_rst_level_e%0d", e), level, (e >= 5));
    end

    // Reset while PRESSED clears level immediately.
    #2 rst = 1'b0;
    #1;
    chk("pressed_rst_level", level, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    btn_in = 1'b0;
    cycles(10);

    // Randomised runs of 1..8 cycles with occasional mid-cycle resets.
    for (int r = 0; r < 500; r++) begin
      int len;
      btn_in = $urandom_range(0, 1);
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          #2 rst = 1'b0;
          @(negedge clk);
          rst = 1'b1;
        end
        edge_wait();
      end
    end
    btn_in = 1'b0;
    cycles(10);

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
